// File: rtl/systolic_array_controller_if.sv
// Bundle between the matrix source and the systolic array controller.
//   start/abort     : host request and cancel
//   a_mat/b_mat     : N*N operand matrices, row-major, DW bits per element
//   a_edge/b_edge   : per-lane operands for the array's left and top edges
//   pe_init         : accumulator clear broadcast to every PE
//   busy/done       : sequence status; done is a one-cycle pulse
// master = matrix source side, slave = controller side.
interface systolic_array_controller_if #(
  parameter int N  = 3,
  parameter int DW = 8
);
  logic              start;
  logic              abort;
  logic [N*N*DW-1:0] a_mat;
  logic [N*N*DW-1:0] b_mat;
  logic [N*DW-1:0]   a_edge;
  logic [N*DW-1:0]   b_edge;
  logic              pe_init;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, a_mat, b_mat,
    input  a_edge, b_edge, pe_init, busy, done
  );

  modport slave (
    input  start, abort, a_mat, b_mat,
    output a_edge, b_edge, pe_init, busy, done
  );
endinterface

// File: rtl/systolic_array_controller.sv
// Sequencer for an N x N output-stationary systolic array.
// Captures A and B on start, clears the PE accumulators, then feeds the
// left edge with A rows and the top edge with B columns using the diagonal
// skew that makes A[i][k] and B[k][j] meet in PE(i,j) at step i+j+k.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of systolic_array_controller_if (see interface file)
// All outputs are flops decoded from the next state/counter, so nothing
// combinational reaches the outputs from start/abort/matrices.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; edges 0
// S_CLEAR | one cycle of pe_init to zero the accumulators
// S_FEED  | 3N-2 steps of skewed operand injection, counter t = 0..3N-3
// S_DRAIN | one cycle so the last MAC in PE(N-1,N-1) registers
// S_DONE  | one-cycle done pulse; start here begins a new capture
module systolic_array_controller #(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input logic                     clk,
  input logic                     rst,
  systolic_array_controller_if.slave bus
);

  localparam int STEPS = 3 * N - 2;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] T_LAST = CW'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N*N*DW-1:0] a_reg_q, a_reg_d;
  logic [N*N*DW-1:0] b_reg_q, b_reg_d;
  logic [N*DW-1:0]   a_edge_q, a_edge_d;
  logic [N*DW-1:0]   b_edge_q, b_edge_d;
  logic              pe_init_q, pe_init_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      a_edge_q  <= '0;
      b_edge_q  <= '0;
      pe_init_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      a_edge_q  <= a_edge_d;
      b_edge_q  <= b_edge_d;
      pe_init_q <= pe_init_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state, step counter and operand capture.
  // abort is only looked at in the busy states, and there it beats the
  // counter-driven exits; in IDLE/DONE start alone decides.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          a_reg_d = bus.a_mat;
          b_reg_d = bus.b_mat;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = bus.abort ? S_IDLE : S_FEED;
      end
      S_FEED: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == T_LAST) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        state_d = bus.abort ? S_IDLE : S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the flops present the values
  // belonging to the cycle being entered.
  // Lane x of the left edge carries A[x][k] at step x+k; lane x of the top
  // edge carries B[k][x] at the same step. Only one k matches per lane.
  always_comb begin
    a_edge_d  = '0;
    b_edge_d  = '0;
    pe_init_d = (state_d == S_CLEAR);
    busy_d    = (state_d == S_CLEAR) || (state_d == S_FEED) ||
                (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    if (state_d == S_FEED) begin
      for (int x = 0; x < N; x++) begin
        for (int k = 0; k < N; k++) begin
          if (cnt_d == CW'(x + k)) begin
            a_edge_d[x*DW +: DW] = a_reg_q[(x*N + k)*DW +: DW];
            b_edge_d[x*DW +: DW] = b_reg_q[(k*N + x)*DW +: DW];
          end
        end
      end
    end
  end

  assign bus.a_edge  = a_edge_q;
  assign bus.b_edge  = b_edge_q;
  assign bus.pe_init = pe_init_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_systolic_array_controller.sv
module tb_systolic_array_controller;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int P  = 3 * N + 1;

  typedef int mat_t [N][N];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_array_controller_if #(.N(N), .DW(DW)) bus();

  systolic_array_controller #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // ---------------- behavioural PE grid attached to the edges -------------
  int acc [N][N];
  int fa  [N][N];
  int fb  [N][N];

  function automatic int lane(input logic [N*DW-1:0] v, input int i);
    return int'(v[i*DW +: DW]);
  endfunction

  function automatic int ain(input int i, input int j);
    return (j == 0) ? lane(bus.a_edge, i) : fa[i][j-1];
  endfunction

  function automatic int bin(input int i, input int j);
    return (i == 0) ? lane(bus.b_edge, j) : fb[i-1][j];
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!rst || bus.pe_init) begin
          acc[i][j] <= 0;
          fa[i][j]  <= 0;
          fb[i][j]  <= 0;
        end else begin
          acc[i][j] <= acc[i][j] + ain(i, j) * bin(i, j);
          fa[i][j]  <= ain(i, j);
          fb[i][j]  <= bin(i, j);
        end
      end
    end
  end

  // ---------------- reference model --------------------------------------
  function automatic logic [N*N*DW-1:0] pack(input mat_t m);
    logic [N*N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        v[(i*N + k)*DW +: DW] = DW'(m[i][k]);
    return v;
  endfunction

  function automatic void rnd_mat(output mat_t m);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        m[i][k] = int'($urandom_range(0, 255));
  endfunction

  function automatic void matmul(input mat_t a, input mat_t b, output mat_t c);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c[i][j] = 0;
        for (int k = 0; k < N; k++) c[i][j] += a[i][k] * b[k][j];
      end
  endfunction

  // Phase = cycles since the start-sampling edge (1..P), 0 = idle.
  function automatic void expect_at(input int ph, input mat_t a, input mat_t b,
                                    output logic [N*DW-1:0] ae,
                                    output logic [N*DW-1:0] be,
                                    output logic pi, output logic bz,
                                    output logic dn);
    int t;
    ae = '0; be = '0;
    pi = (ph == 1);
    bz = (ph >= 1) && (ph <= 3 * N);
    dn = (ph == P);
    if (ph >= 2 && ph <= 3 * N - 1) begin
      t = ph - 2;
      for (int x = 0; x < N; x++) begin
        if (t - x >= 0 && t - x < N) begin
          ae[x*DW +: DW] = DW'(a[x][t-x]);
          be[x*DW +: DW] = DW'(b[t-x][x]);
        end
      end
    end
  endfunction

  // ---------------- checking helpers --------------------------------------
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_phase(input string tag, input int ph,
                             input mat_t a, input mat_t b);
    logic [N*DW-1:0] ae, be;
    logic pi, bz, dn;
    expect_at(ph, a, b, ae, be, pi, bz, dn);
    check($sformatf("%s ph%0d a_edge", tag, ph), 64'(bus.a_edge), 64'(ae));
    check($sformatf("%s ph%0d b_edge", tag, ph), 64'(bus.b_edge), 64'(be));
    check($sformatf("%s ph%0d pe_init", tag, ph), 64'(bus.pe_init), 64'(pi));
    check($sformatf("%s ph%0d busy", tag, ph), 64'(bus.busy), 64'(bz));
    check($sformatf("%s ph%0d done", tag, ph), 64'(bus.done), 64'(dn));
  endtask

  task automatic check_grid(input string tag, input mat_t c);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s C[%0d][%0d]", tag, i, j),
              64'(acc[i][j]), 64'(c[i][j]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; spulse >= 1 raises start for one cycle at that phase,
  // spot enables the hand-derived edge values of the directed example.
  task automatic run_op(input string tag, input mat_t a, input mat_t b,
                        input int spulse, input bit spot);
    mat_t junk, c;
    bus.a_mat = pack(a);
    bus.b_mat = pack(b);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rnd_mat(junk); bus.a_mat = pack(junk);
    rnd_mat(junk); bus.b_mat = pack(junk);
    matmul(a, b, c);
    for (int ph = 1; ph <= P; ph++) begin
      check_phase(tag, ph, a, b);
      if (spot) begin
        case (ph)
          2: begin
            check("skew t0 a_edge", 64'(bus.a_edge), 64'h000001);
            check("skew t0 b_edge", 64'(bus.b_edge), 64'h000002);
          end
          4: begin
            check("skew t2 a_edge", 64'(bus.a_edge), 64'h040303);
            check("skew t2 b_edge", 64'(bus.b_edge), 64'h010102);
          end
          8: begin
            check("skew t6 a_edge", 64'(bus.a_edge), 64'h0);
            check("skew t6 b_edge", 64'(bus.b_edge), 64'h0);
          end
          default: ;
        endcase
      end
      if (ph == P) check_grid(tag, c);
      bus.start = (ph == spulse);
      tick();
    end
    bus.start = 1'b0;
    check_phase({tag, " after"}, 0, a, b);
  endtask

  // ---------------- stimulus ---------------------------------------------
  mat_t ma, mb, ma2, mb2, mid, mc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ma  = '{'{1, 2, 3}, '{2, 3, 1}, '{4, 3, 1}};
    mb  = '{'{2, 3, 1}, '{3, 1, 3}, '{2, 1, 4}};
    mid = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};

    // Reset held with start and nonzero operands present.
    rst = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.a_mat = pack(ma);
    bus.b_mat = pack(mb);
    repeat (3) tick();
    check_phase("reset held", 0, ma, mb);
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    check_phase("reset released", 0, ma, mb);

    // abort while idle does nothing.
    bus.abort = 1'b1;
    tick();
    check_phase("idle abort", 0, ma, mb);
    bus.abort = 1'b0;

    // Directed skew example and its expected product.
    run_op("skew", ma, mb, 0, 1'b1);
    mc = '{'{14, 8, 19}, '{15, 10, 15}, '{19, 16, 17}};
    check_grid("skew const", mc);

    // Identity times B gives B.
    mb2 = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    run_op("ident", mid, mb2, 0, 1'b0);
    check_grid("ident const", mb2);

    // Random operands.
    for (int r = 0; r < 4; r++) begin
      rnd_mat(ma2); rnd_mat(mb2);
      run_op($sformatf("rand%0d", r), ma2, mb2, 0, 1'b0);
    end

    // start pulsed during FEED (t=2) is ignored.
    rnd_mat(ma2); rnd_mat(mb2);
    run_op("start in feed", ma2, mb2, 4, 1'b0);

    // Back-to-back with start held; abort in DONE loses to start.
    rnd_mat(ma); rnd_mat(mb); rnd_mat(ma2); rnd_mat(mb2);
    bus.a_mat = pack(ma);
    bus.b_mat = pack(mb);
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 2 * P; c++) begin
      int ph;
      ph = ((c - 1) % P) + 1;
      if (c <= P) begin
        check_phase("b2b first", ph, ma, mb);
        if (ph == P) begin matmul(ma, mb, mc); check_grid("b2b first", mc); end
      end else begin
        check_phase("b2b second", ph, ma2, mb2);
        if (ph == P) begin matmul(ma2, mb2, mc); check_grid("b2b second", mc); end
      end
      if (c == 5) begin
        bus.a_mat = pack(ma2);
        bus.b_mat = pack(mb2);
      end
      bus.abort = (c == P);
      if (c == 2 * P) bus.start = 1'b0;
      tick();
    end
    bus.abort = 1'b0;
    check_phase("b2b after", 0, ma2, mb2);

    // abort at FEED t=3 returns to idle with no done.
    rnd_mat(ma); rnd_mat(mb);
    bus.a_mat = pack(ma);
    bus.b_mat = pack(mb);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int ph = 1; ph <= 5; ph++) begin
      check_phase("abort run", ph, ma, mb);
      bus.abort = (ph == 5);
      tick();
    end
    bus.abort = 1'b0;
    for (int c = 0; c < P; c++) begin
      check_phase("aborted", 0, ma, mb);
      tick();
    end
    rnd_mat(ma2); rnd_mat(mb2);
    run_op("after abort", ma2, mb2, 0, 1'b0);

    // Asynchronous reset mid-FEED clears outputs immediately.
    rnd_mat(ma); rnd_mat(mb);
    bus.a_mat = pack(ma);
    bus.b_mat = pack(mb);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1 check_phase("async reset", 0, ma, mb);
    tick();
    rst = 1'b1;
    for (int c = 0; c < P; c++) begin
      check_phase("post reset", 0, ma, mb);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
